a0_trace_fifo: RTL

//  Downstream observer of the single-cycle CPU top: samples the CPU a0 result

---
 rtl/a0_trace_fifo.sv | 135 +++++++++++++
 1 files changed

// File: rtl/a0_trace_fifo.sv
// a0_trace_fifo: observes the CPU a0 result and records every new value in a FIFO.
// The FIFO drains through a valid/ready port, so a slow display/host side never
// misses an a0 update. Values lost to a full FIFO are counted and flagged.
//
// Ports:
//   clk, rst    rising-edge clock; synchronous active-high reset
//   a0          CPU a0 register value being observed
//   capture_en  sample a0 this cycle
//   clear       synchronous flush of the FIFO, statistics and change detector
//   out_data    head entry (0 when empty), registered show-ahead
//   out_valid   head entry available
//   out_ready   consumer accepts the head entry
//   count       entries held, 0..DEPTH
//   drop_cnt    saturating count of values lost to a full FIFO
//   overflow    sticky flag, set on the first drop
module a0_trace_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    a0,
  input  logic                     capture_en,
  input  logic                     clear,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_WIDTH-1:0]     drop_cnt,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] a0_q;
  logic                  seen;

  logic                  cap;
  logic                  pop;
  logic                  full;
  logic                  push;
  logic                  drop;
  logic [PTR_W-1:0]      rd_ptr_n;
  logic [CNT_W-1:0]      count_n;
  logic [DATA_WIDTH-1:0] head_n;

  // Change detection, push/pop qualification and next head value.
  always_comb begin
    cap      = 1'b0;
    pop      = 1'b0;
    full     = 1'b0;
    push     = 1'b0;
    drop     = 1'b0;
    rd_ptr_n = rd_ptr;
    count_n  = count;
    head_n   = '0;

    cap  = capture_en & (~seen | (a0 != a0_q));
    pop  = out_valid & out_ready;
    full = (count == CNT_W'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push = cap & (~full | pop);
    drop = cap & full & ~pop;

    rd_ptr_n = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_n  = count + CNT_W'(push) - CNT_W'(pop);

    // Head register is show-ahead: if the next head is the slot being written
    // this cycle (push into empty, or last entry popped), forward a0 directly.
    if (count_n == '0) begin
      head_n = '0;
    end else if (push && (wr_ptr == rd_ptr_n)) begin
      head_n = a0;
    end else begin
      head_n = mem[rd_ptr_n];
    end
  end

  // Storage array; contents are don't-care outside the count window.
  always_ff @(posedge clk) begin
    if (!rst && !clear && push) begin
      mem[wr_ptr] <= a0;
    end
  end

  // Pointers, occupancy, head register and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      a0_q      <= '0;
      seen      <= 1'b0;
    end else if (clear) begin
      // a0_q is kept; clearing seen forces the next capture to push.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      seen      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      out_data  <= head_n;
      out_valid <= (count_n != '0);
      // Dropped values are not retried: a0_q tracks a0 whenever sampling.
      if (capture_en) begin
        a0_q <= a0;
        seen <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule
